// File: rtl/fifo_sync_prog.sv
// Single-clock synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, exact occupancy and optional first-word-fall-through.
module fifo_sync_prog #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  dout_valid,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   fifo_depth,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_afull,
    output logic                  fifo_aempty,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int unsigned          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]  DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]  PTR_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] depth_q, depth_d;

    logic full_q, full_d;
    logic empty_q, empty_d;
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    logic [DATA_WIDTH-1:0] dataout_q;
    logic                  dout_valid_q;

    logic ptr_full, ptr_empty;
    logic push_acc, pop_acc;
    logic ovf_event, udf_event;

    // Extra wrap bit on each pointer distinguishes full from empty when the indices match.
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                       (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    // A pop on a full FIFO frees the slot the same cycle, so the push is still taken.
    assign push_acc  = push & (~ptr_full | pop);
    assign pop_acc   = pop & ~ptr_empty;

    assign ovf_event = push & ptr_full & ~pop;
    assign udf_event = pop & ptr_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        depth_d  = depth_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_acc, pop_acc})
            2'b10:   depth_d = depth_q + PTR_ONE;
            2'b01:   depth_d = depth_q - PTR_ONE;
            default: depth_d = depth_q;
        endcase
    end

    // Status flags come from the next-state depth so they line up with fifo_depth.
    always_comb begin
        full_d   = (depth_d == DEPTH_CNT);
        empty_d  = (depth_d == '0);
        afull_d  = (depth_d >= afull_thresh);
        aempty_d = (depth_d <= aempty_thresh);
        ovf_d    = ovf_event | (ovf_q & ~clr_err);
        udf_d    = udf_event | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            depth_q  <= depth_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= datain;
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic [ADDR_WIDTH-1:0] head_idx;
        logic [DATA_WIDTH-1:0] head_word;

        // The word being written this cycle is the next head only when it lands on
        // rd_ptr_d, i.e. the FIFO is otherwise empty afterwards; bypass the array then.
        always_comb begin
            head_idx  = rd_ptr_d[ADDR_WIDTH-1:0];
            head_word = mem[head_idx];
            if (push_acc && (wr_ptr_q[ADDR_WIDTH-1:0] == head_idx)) begin
                head_word = datain;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dataout_q    <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                if (depth_d != '0) begin
                    dataout_q <= head_word;
                end
                dout_valid_q <= (depth_d != '0);
            end
        end
    end else begin : g_std
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dataout_q    <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                if (pop_acc) begin
                    dataout_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                end
                dout_valid_q <= pop_acc;
            end
        end
    end

    assign dataout        = dataout_q;
    assign dout_valid     = dout_valid_q;
    assign fifo_depth     = depth_q;
    assign fifo_full      = full_q;
    assign fifo_empty     = empty_q;
    assign fifo_afull     = afull_q;
    assign fifo_aempty    = aempty_q;
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = udf_q;

endmodule
